// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator
// Sums N_TERMS consecutive unsigned products from the multiplier into one
// dot-product element. Each completed sum is offered on a one-entry
// valid/ready output register. Upstream cannot be stalled, so a result that
// completes while the output register is still full and not being drained
// is dropped, and the sticky overflow flag is raised.
module dot_product_accumulator #(
    parameter int PROD_W  = 64,
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 72
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PROD_W-1:0]          prod_in,
    input  logic                       prod_valid,
    input  logic                       clear,
    output logic [ACC_W-1:0]           acc_out,
    output logic                       acc_valid,
    input  logic                       acc_ready,
    output logic [$clog2(N_TERMS):0]   term_cnt,
    output logic                       busy,
    output logic                       overflow
);

    // Counter is one bit wider than needed to index N_TERMS so that
    // N_TERMS=1 still yields a legal one-bit counter.
    localparam int CNT_W = $clog2(N_TERMS) + 1;
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
    localparam logic [ACC_W-1:0] ZERO_ACC = {ACC_W{1'b0}};

    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Partial-sum state
    logic [CNT_W-1:0] term_cnt_q;
    logic [CNT_W-1:0] term_cnt_d;
    logic [ACC_W-1:0] partial_q;
    logic [ACC_W-1:0] partial_d;

    // Output register state
    out_state_e       out_state_q;
    out_state_e       out_state_d;
    logic [ACC_W-1:0] acc_out_q;
    logic [ACC_W-1:0] acc_out_d;
    logic             overflow_q;
    logic             overflow_d;

    // Datapath helpers
    logic [ACC_W-1:0] prod_ext_s;
    logic [ACC_W-1:0] sum_s;
    logic             take_s;
    logic             complete_s;

    // Term acceptance, completion detect and the running sum including this term.
    always_comb begin
        prod_ext_s = ACC_W'(prod_in);
        // clear has priority: a product arriving together with clear is dropped.
        take_s     = prod_valid & ~clear;
        complete_s = take_s & (term_cnt_q == LAST_CNT);
        // The first term of a dot product loads directly so a stale partial
        // can never leak into the next element.
        if (term_cnt_q == ZERO_CNT) begin
            sum_s = prod_ext_s;
        end else begin
            sum_s = partial_q + prod_ext_s;
        end
    end

    // Next state of the partial sum and term counter.
    always_comb begin
        term_cnt_d = term_cnt_q;
        partial_d  = partial_q;
        if (clear) begin
            term_cnt_d = ZERO_CNT;
            partial_d  = ZERO_ACC;
        end else if (complete_s) begin
            // The finished sum leaves through the output register; the
            // partial is free for the next element on the very next cycle.
            term_cnt_d = ZERO_CNT;
            partial_d  = ZERO_ACC;
        end else if (take_s) begin
            term_cnt_d = term_cnt_q + ONE_CNT;
            partial_d  = sum_s;
        end else begin
            term_cnt_d = term_cnt_q;
            partial_d  = partial_q;
        end
    end

    // Next state of the output register (EMPTY/FULL) and the sticky overflow flag.
    always_comb begin
        out_state_d = out_state_q;
        acc_out_d   = acc_out_q;
        overflow_d  = overflow_q;
        case (out_state_q)
            OUT_EMPTY: begin
                if (complete_s) begin
                    acc_out_d   = sum_s;
                    out_state_d = OUT_FULL;
                end else begin
                    out_state_d = OUT_EMPTY;
                end
            end
            OUT_FULL: begin
                if (complete_s) begin
                    if (acc_ready) begin
                        // Old result leaves while the new one arrives.
                        acc_out_d   = sum_s;
                        out_state_d = OUT_FULL;
                    end else begin
                        // Held result must stay stable; the new one is lost.
                        overflow_d  = 1'b1;
                        out_state_d = OUT_FULL;
                    end
                end else if (acc_ready) begin
                    // acc_out keeps its last value after the hand-off.
                    out_state_d = OUT_EMPTY;
                end else begin
                    out_state_d = OUT_FULL;
                end
            end
            default: begin
                out_state_d = OUT_EMPTY;
            end
        endcase
        // clear never coincides with a completion, so it cannot mask a new drop.
        if (clear) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_d;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            term_cnt_q  <= ZERO_CNT;
            partial_q   <= ZERO_ACC;
            out_state_q <= OUT_EMPTY;
            acc_out_q   <= ZERO_ACC;
            overflow_q  <= 1'b0;
        end else begin
            term_cnt_q  <= term_cnt_d;
            partial_q   <= partial_d;
            out_state_q <= out_state_d;
            acc_out_q   <= acc_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign acc_out   = acc_out_q;
    assign acc_valid = (out_state_q == OUT_FULL);
    assign term_cnt  = term_cnt_q;
    assign busy      = (term_cnt_q != ZERO_CNT);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Self-checking bench for dot_product_accumulator: directed scenarios plus a
// randomized run, compared against a term-list reference model with a
// scoreboard of expected delivered results.
module tb_dot_product_accumulator;

    localparam int PROD_W  = 64;
    localparam int N_TERMS = 4;
    localparam int ACC_W   = 72;
    localparam int CNT_W   = $clog2(N_TERMS) + 1;

    logic              clk;
    logic              reset;
    logic [PROD_W-1:0] prod_in;
    logic              prod_valid;
    logic              clear;
    logic [ACC_W-1:0]  acc_out;
    logic              acc_valid;
    logic              acc_ready;
    logic [CNT_W-1:0]  term_cnt;
    logic              busy;
    logic              overflow;

    dot_product_accumulator #(
        .PROD_W (PROD_W),
        .N_TERMS(N_TERMS),
        .ACC_W  (ACC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .prod_in   (prod_in),
        .prod_valid(prod_valid),
        .clear     (clear),
        .acc_out   (acc_out),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .term_cnt  (term_cnt),
        .busy      (busy),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the list of terms in the current element, the
    // expected output register contents and a queue of results that will
    // be handed to the consumer.
    logic [ACC_W-1:0] m_terms[$];
    logic             m_valid;
    logic [ACC_W-1:0] m_out;
    logic             m_ovf;
    logic [ACC_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_terms.delete();
        exp_q.delete();
        m_valid = 1'b0;
        m_out   = '0;
        m_ovf   = 1'b0;
    endfunction

    // One clock edge worth of behaviour, given the inputs applied before it.
    function automatic void model_edge(input logic v, input logic [PROD_W-1:0] p,
                                       input logic c, input logic r);
        logic [ACC_W-1:0] s;
        logic comp;
        comp = v && !c && (m_terms.size() == N_TERMS - 1);
        s = ACC_W'(p);
        foreach (m_terms[i]) s = s + m_terms[i];
        if (c) begin
            m_terms.delete();
            m_ovf = 1'b0;
        end else if (v) begin
            if (comp) m_terms.delete();
            else m_terms.push_back(ACC_W'(p));
        end
        if (comp) begin
            if (!m_valid || r) begin
                m_out   = s;
                m_valid = 1'b1;
                exp_q.push_back(s);
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
    endfunction

    // Monitor: state comparison every cycle, scoreboard pop on each hand-off.
    always @(negedge clk) begin
        if (!reset) begin
            chk("acc_valid", ACC_W'(acc_valid), ACC_W'(m_valid));
            chk("acc_out",   acc_out,           m_out);
            chk("overflow",  ACC_W'(overflow),  ACC_W'(m_ovf));
            chk("term_cnt",  ACC_W'(term_cnt),  ACC_W'(m_terms.size()));
            chk("busy",      ACC_W'(busy),      ACC_W'(m_terms.size() != 0));
            if (acc_valid && acc_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected", ACC_W'(1), ACC_W'(0));
                end else begin
                    chk("sb_result", acc_out, exp_q.pop_front());
                end
            end
        end
    end

    task automatic step(input logic v, input logic [PROD_W-1:0] p, input logic c, input logic r);
        prod_valid = v;
        prod_in    = p;
        clear      = c;
        acc_ready  = r;
        @(posedge clk);
        model_edge(v, p, c, r);
        #1;
    endtask

    task automatic idle(input logic r);
        step(1'b0, '0, 1'b0, r);
    endtask

    int vcount;
    logic [PROD_W-1:0] pr;
    logic [PROD_W-1:0] all_ones;

    initial begin
        all_ones   = {PROD_W{1'b1}};
        reset      = 1'b1;
        prod_in    = '0;
        prod_valid = 1'b0;
        clear      = 1'b0;
        acc_ready  = 1'b0;
        model_reset();
        #1;
        chk("rst_acc_out",   acc_out,            '0);
        chk("rst_acc_valid", ACC_W'(acc_valid),  '0);
        chk("rst_term_cnt",  ACC_W'(term_cnt),   '0);
        chk("rst_busy",      ACC_W'(busy),       '0);
        chk("rst_overflow",  ACC_W'(overflow),   '0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // 1,2,3,4 -> 10 one cycle after the last term, gone the next cycle
        for (int i = 1; i <= 4; i++) step(1'b1, PROD_W'(i), 1'b0, 1'b1);
        chk("t1_valid", ACC_W'(acc_valid), ACC_W'(1));
        chk("t1_sum",   acc_out, ACC_W'(10));
        idle(1'b1);
        chk("t1_valid_drop", ACC_W'(acc_valid), ACC_W'(0));

        // Maximum products, no wrap
        for (int i = 0; i < 4; i++) step(1'b1, all_ones, 1'b0, 1'b1);
        chk("t2_max", acc_out, 72'h3_FFFF_FFFF_FFFF_FFFC);
        idle(1'b1);

        // Back-to-back 1..8 -> 10, 26 on two separated cycles
        vcount = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, PROD_W'(i), 1'b0, 1'b1);
            if (acc_valid) vcount++;
            if (i == 4) chk("t3_first", acc_out, ACC_W'(10));
            if (i == 5) chk("t3_gap", ACC_W'(acc_valid), ACC_W'(0));
            if (i == 8) chk("t3_second", acc_out, ACC_W'(26));
        end
        chk("t3_valid_cycles", ACC_W'(vcount), ACC_W'(2));
        idle(1'b1);

        // Overflow: held result stays, second is dropped
        for (int i = 1; i <= 8; i++) step(1'b1, PROD_W'(i), 1'b0, 1'b0);
        chk("t4_hold", acc_out, ACC_W'(10));
        chk("t4_ovf",  ACC_W'(overflow), ACC_W'(1));
        idle(1'b1);
        chk("t4_drain", ACC_W'(acc_valid), ACC_W'(0));
        chk("t4_ovf_sticky", ACC_W'(overflow), ACC_W'(1));
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t4_ovf_clear", ACC_W'(overflow), ACC_W'(0));

        // clear beats a simultaneous product
        step(1'b1, PROD_W'(7), 1'b0, 1'b1);
        step(1'b1, PROD_W'(7), 1'b0, 1'b1);
        step(1'b1, PROD_W'(9), 1'b1, 1'b1);
        chk("t5_cleared_cnt", ACC_W'(term_cnt), ACC_W'(0));
        for (int i = 0; i < 4; i++) step(1'b1, PROD_W'(5), 1'b0, 1'b1);
        chk("t5_sum", acc_out, ACC_W'(20));
        chk("t5_cnt", ACC_W'(term_cnt), ACC_W'(0));
        idle(1'b1);

        // Asynchronous reset mid-cycle with a held result and a partial in flight
        for (int i = 1; i <= 4; i++) step(1'b1, PROD_W'(i), 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) step(1'b1, PROD_W'(i), 1'b0, 1'b0);
        chk("t6_pre_valid", ACC_W'(acc_valid), ACC_W'(1));
        #2 reset = 1'b1;
        #1;
        chk("t6_acc_out",   acc_out,           '0);
        chk("t6_acc_valid", ACC_W'(acc_valid), '0);
        chk("t6_term_cnt",  ACC_W'(term_cnt),  '0);
        chk("t6_busy",      ACC_W'(busy),      '0);
        chk("t6_overflow",  ACC_W'(overflow),  '0);
        model_reset();
        prod_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, PROD_W'(1), 1'b0, 1'b1);
        chk("t6_sum", acc_out, ACC_W'(4));
        idle(1'b1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) pr = all_ones;
            else pr = {$urandom, $urandom};
            step(($urandom_range(0, 9) < 7), pr, ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 9) < 6));
        end

        // Drain and confirm every expected result was delivered
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk("sb_empty", ACC_W'(exp_q.size()), ACC_W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
